// File: rtl/clk_pkg.sv
// Shared types, defaults and helpers for the clock-enable divider bank.
package clk_pkg;

    localparam int unsigned NCH_DEF   = 4;
    localparam int unsigned DIV_W_DEF = 16;

    // Lock-aware reset sequencer states.
    typedef enum logic [1:0] {
        StHold,
        StStretch,
        StRun
    } seq_state_t;

    // Channel-index width, never narrower than one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One divider channel: up-counter with active/shadow divisor, registered
// clock-enable pulse and square-wave output.
module clk_en_chan import clk_pkg::*; #(
    parameter int unsigned      DIV_W   = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DEF_DIV = DIV_W'(96)
) (
    input  logic             clk_96M,
    input  logic             n_reset,
    input  logic             run,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             ce,
    output logic             sq
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             ce_q, ce_d;
    logic             sq_q, sq_d;
    logic [DIV_W-1:0] shadow_eff;
    logic             wrap;

    // Next-state: sync beats hold, hold beats disable, disable beats counting.
    always_comb begin
        // A write in the same cycle as a load is written through.
        shadow_eff = wr ? wr_div : shadow_q;
        wrap       = run && (active_q != '0) && (cnt_q == active_q - DIV_W'(1));
        shadow_d   = shadow_eff;
        active_d   = active_q;
        cnt_d      = cnt_q;
        ce_d       = 1'b0;
        sq_d       = sq_q;
        if (sync) begin
            cnt_d    = '0;
            sq_d     = 1'b0;
            active_d = shadow_eff;
        end else if (!run) begin
            cnt_d = '0;
            sq_d  = 1'b0;
            if (active_q == '0) begin
                active_d = shadow_eff;
            end
        end else if (active_q == '0) begin
            // Disabled: counter parked, sq frozen, new divisor taken at once.
            cnt_d    = '0;
            active_d = shadow_eff;
        end else if (wrap) begin
            cnt_d    = '0;
            ce_d     = 1'b1;
            sq_d     = ~sq_q;
            active_d = shadow_eff;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clk_96M) begin
        if (!n_reset) begin
            cnt_q    <= '0;
            active_q <= DEF_DIV;
            shadow_q <= DEF_DIV;
            ce_q     <= 1'b0;
            sq_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            ce_q     <= ce_d;
            sq_q     <= sq_d;
        end
    end

    assign ce = ce_q;
    assign sq = sq_q;

endmodule

// File: rtl/clk_en_divider_bank.sv
// Bank of NCH programmable clock-enable dividers on clk_96M, gated by a
// lock-aware reset sequencer that also drives the downstream system reset.
module clk_en_divider_bank import clk_pkg::*; #(
    parameter int unsigned NCH         = NCH_DEF,
    parameter int unsigned DIV_W       = DIV_W_DEF,
    parameter int unsigned DEF_DIV     = 96,
    parameter int unsigned RST_STRETCH = 255,
    localparam int unsigned CH_W       = ch_width(NCH)
) (
    input  logic             clk_96M,
    input  logic             n_reset,
    input  logic             pll_lock,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_sync,
    output logic [NCH-1:0]   ce,
    output logic [NCH-1:0]   sq,
    output logic             rst_out_n,
    output logic             lock_lost
);

    localparam int unsigned ScntW = $clog2(RST_STRETCH + 1);

    logic             lock_meta_q;
    logic             lock_s_q;
    seq_state_t       state_q, state_d;
    logic [ScntW-1:0] scnt_q, scnt_d;
    logic             rst_out_n_q, rst_out_n_d;
    logic             lock_lost_q, lock_lost_d;
    logic [NCH-1:0]   wr;

    // Sequencer next-state: lock must stay high for the full stretch.
    always_comb begin
        state_d     = state_q;
        scnt_d      = scnt_q;
        lock_lost_d = lock_lost_q;
        unique case (state_q)
            StHold: begin
                if (lock_s_q) begin
                    state_d = StStretch;
                    scnt_d  = ScntW'(RST_STRETCH);
                end
            end
            StStretch: begin
                if (!lock_s_q) begin
                    state_d = StHold;
                end else if (scnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    scnt_d = scnt_q - ScntW'(1);
                end
            end
            StRun: begin
                if (!lock_s_q) begin
                    state_d     = StHold;
                    lock_lost_d = 1'b1;
                end
            end
            default: state_d = StHold;
        endcase
        rst_out_n_d = (state_d == StRun);
    end

    // Lock synchroniser and sequencer registers.
    always_ff @(posedge clk_96M) begin
        if (!n_reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= StHold;
            scnt_q      <= '0;
            rst_out_n_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            rst_out_n_q <= rst_out_n_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        // Out-of-range channel indices match no channel and are dropped.
        assign wr[i] = cfg_we && (cfg_ch == CH_W'(i));

        clk_en_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DIV_W'(DEF_DIV))
        ) u_chan (
            .clk_96M (clk_96M),
            .n_reset (n_reset),
            .run     (rst_out_n_q),
            .sync    (cfg_sync),
            .wr      (wr[i]),
            .wr_div  (cfg_div),
            .ce      (ce[i]),
            .sq      (sq[i])
        );
    end

    assign rst_out_n = rst_out_n_q;
    assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_clk_en_divider_bank.sv
// Self-checking bench: directed scenarios plus randomised traffic, with a
// time-stamp based reference model checked every cycle.
module tb_clk_en_divider_bank;

    localparam int unsigned NCH         = 4;
    localparam int unsigned DIV_W       = 16;
    localparam int unsigned DEF_DIV     = 96;
    localparam int unsigned RST_STRETCH = 8;

    logic             clk_96M = 1'b0;
    logic             n_reset;
    logic             pll_lock;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_sync;
    logic [NCH-1:0]   ce;
    logic [NCH-1:0]   sq;
    logic             rst_out_n;
    logic             lock_lost;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_96M = ~clk_96M;

    clk_en_divider_bank #(
        .NCH         (NCH),
        .DIV_W       (DIV_W),
        .DEF_DIV     (DEF_DIV),
        .RST_STRETCH (RST_STRETCH)
    ) dut (
        .clk_96M   (clk_96M),
        .n_reset   (n_reset),
        .pll_lock  (pll_lock),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_sync  (cfg_sync),
        .ce        (ce),
        .sq        (sq),
        .rst_out_n (rst_out_n),
        .lock_lost (lock_lost)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: reset released once lock_s has been seen high on
    // RST_STRETCH+2 consecutive edges; each channel tracks the edge at which
    // its current period started and the number of pulses since alignment.
    int unsigned    cyc = 0;
    bit             ls_meta, ls_sync;
    int unsigned    run_len;
    bit             m_rst, m_lost, m_valid = 1'b0;
    int unsigned    m_act[NCH];
    int unsigned    m_shd[NCH];
    int unsigned    m_t0[NCH];
    int unsigned    m_pulses[NCH];
    logic [NCH-1:0] m_ce;
    logic [NCH-1:0] m_sq;
    int unsigned    nv;

    always @(posedge clk_96M) begin
        cyc++;
        if (!n_reset) begin
            ls_meta = 1'b0;
            ls_sync = 1'b0;
            run_len = 0;
            m_rst   = 1'b0;
            m_lost  = 1'b0;
            m_ce    = '0;
            for (int i = 0; i < NCH; i++) begin
                m_act[i]    = DEF_DIV;
                m_shd[i]    = DEF_DIV;
                m_t0[i]     = cyc + 1;
                m_pulses[i] = 0;
            end
            m_valid = 1'b1;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                nv       = (cfg_we && cfg_ch == i) ? cfg_div : m_shd[i];
                m_shd[i] = nv;
                m_ce[i]  = 1'b0;
                if (cfg_sync) begin
                    m_act[i]    = nv;
                    m_t0[i]     = cyc + 1;
                    m_pulses[i] = 0;
                end else if (!m_rst || m_act[i] == 0) begin
                    m_t0[i] = cyc + 1;
                    if (!m_rst) m_pulses[i] = 0;
                    if (m_act[i] == 0) m_act[i] = nv;
                end else if (cyc - m_t0[i] + 1 == m_act[i]) begin
                    m_ce[i] = 1'b1;
                    m_pulses[i]++;
                    m_t0[i]  = cyc + 1;
                    m_act[i] = nv;
                end
            end
            if (ls_sync) run_len++;
            else run_len = 0;
            if (m_rst && !ls_sync) m_lost = 1'b1;
            m_rst   = (run_len >= RST_STRETCH + 2);
            ls_sync = ls_meta;
            ls_meta = pll_lock;
        end
    end

    always @(negedge clk_96M) begin
        if (m_valid) begin
            for (int i = 0; i < NCH; i++) m_sq[i] = m_pulses[i][0];
            check_eq("model_rst_out_n", 32'(rst_out_n), 32'(m_rst));
            check_eq("model_lock_lost", 32'(lock_lost), 32'(m_lost));
            check_eq("model_ce", 32'(ce), 32'(m_ce));
            check_eq("model_sq", 32'(sq), 32'(m_sq));
        end
    end

    // Cycles between consecutive ce pulses (or sq rising edges); -1 on timeout.
    task automatic edge_gap(input bit use_sq, input int ch, input int lim, output int gap);
        logic prev;
        bit   hit;
        bit   found;
        gap   = -1;
        found = 1'b0;
        prev  = sq[ch];
        for (int n = 0; n < lim && !found; n++) begin
            @(negedge clk_96M);
            hit   = use_sq ? (sq[ch] && !prev) : ce[ch];
            prev  = sq[ch];
            found = hit;
        end
        if (found) begin
            found = 1'b0;
            for (int n = 1; n <= lim && !found; n++) begin
                @(negedge clk_96M);
                hit  = use_sq ? (sq[ch] && !prev) : ce[ch];
                prev = sq[ch];
                if (hit) begin
                    gap   = n;
                    found = 1'b1;
                end
            end
        end
    endtask

    task automatic wr_div(input int ch, input int d);
        cfg_we  = 1'b1;
        cfg_ch  = ch[1:0];
        cfg_div = d[DIV_W-1:0];
        @(negedge clk_96M);
        cfg_we  = 1'b0;
    endtask

    initial begin
        int   gap;
        int   cnt;
        logic s;
        n_reset  = 1'b0;
        pll_lock = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_div  = '0;
        cfg_sync = 1'b0;
        repeat (3) @(negedge clk_96M);
        check_eq("reset_ce", 32'(ce), 32'd0);
        check_eq("reset_sq", 32'(sq), 32'd0);
        check_eq("reset_rst_out_n", 32'(rst_out_n), 32'd0);
        check_eq("reset_lock_lost", 32'(lock_lost), 32'd0);
        n_reset = 1'b1;
        repeat (4) @(negedge clk_96M);

        // Lock release: first edge sampling lock is k, release after k+3+S.
        pll_lock = 1'b1;
        repeat (RST_STRETCH + 3) @(posedge clk_96M);
        @(negedge clk_96M);
        check_eq("release_early", 32'(rst_out_n), 32'd0);
        @(negedge clk_96M);
        check_eq("release", 32'(rst_out_n), 32'd1);
        check_eq("release_lock_lost", 32'(lock_lost), 32'd0);

        edge_gap(1'b0, 0, 300, gap);
        check_eq("def_ce_period", gap, 32'd96);
        edge_gap(1'b1, 0, 500, gap);
        check_eq("def_sq_period", gap, 32'd192);

        // Lock loss in RUN.
        pll_lock = 1'b0;
        repeat (2) @(posedge clk_96M);
        @(negedge clk_96M);
        check_eq("loss_still_run", 32'(rst_out_n), 32'd1);
        @(negedge clk_96M);
        check_eq("loss_drop", 32'(rst_out_n), 32'd0);
        check_eq("loss_sticky", 32'(lock_lost), 32'd1);
        repeat (2) @(negedge clk_96M);
        check_eq("loss_ce_stop", 32'(ce), 32'd0);
        check_eq("loss_sq_stop", 32'(sq), 32'd0);

        // One-cycle glitch in STRETCH restarts the full stretch.
        pll_lock = 1'b1;
        repeat (6) @(negedge clk_96M);
        pll_lock = 1'b0;
        @(negedge clk_96M);
        pll_lock = 1'b1;
        repeat (RST_STRETCH + 3) @(posedge clk_96M);
        @(negedge clk_96M);
        check_eq("restart_early", 32'(rst_out_n), 32'd0);
        @(negedge clk_96M);
        check_eq("restart_release", 32'(rst_out_n), 32'd1);
        check_eq("restart_lock_lost", 32'(lock_lost), 32'd1);

        // Divisor 3 after current wrap, then divisor 1 is a constant enable.
        wr_div(1, 3);
        edge_gap(1'b0, 1, 200, gap);
        check_eq("div3_period", gap, 32'd3);
        wr_div(1, 1);
        repeat (6) @(negedge clk_96M);
        cnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk_96M);
            if (ce[1]) cnt++;
        end
        check_eq("div1_const", cnt, 32'd8);

        // Disable ch2, then re-enable with 5.
        wr_div(2, 0);
        repeat (110) @(negedge clk_96M);
        s   = sq[2];
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_96M);
            if (!ce[2] && sq[2] == s) cnt++;
        end
        check_eq("disable_frozen", cnt, 32'd20);
        cfg_we  = 1'b1;
        cfg_ch  = 2'd2;
        cfg_div = DIV_W'(5);
        @(negedge clk_96M);
        cfg_we = 1'b0;
        repeat (4) @(posedge clk_96M);
        @(negedge clk_96M);
        check_eq("enable_wait", 32'(ce[2]), 32'd0);
        @(negedge clk_96M);
        check_eq("enable_first", 32'(ce[2]), 32'd1);

        // cfg_sync with concurrent write to ch3.
        wr_div(0, 4);
        cfg_sync = 1'b1;
        cfg_we   = 1'b1;
        cfg_ch   = 2'd3;
        cfg_div  = DIV_W'(4);
        @(negedge clk_96M);
        cfg_sync = 1'b0;
        cfg_we   = 1'b0;
        check_eq("sync_sq", 32'(sq), 32'd0);
        check_eq("sync_ce", 32'(ce), 32'd0);
        repeat (3) @(posedge clk_96M);
        @(negedge clk_96M);
        check_eq("sync_pre", 32'({ce[3], ce[0]}), 32'd0);
        @(negedge clk_96M);
        check_eq("sync_align", 32'({ce[3], ce[0]}), 32'd3);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_ch   = 2'($urandom_range(0, 3));
            cfg_div  = DIV_W'($urandom_range(0, 9));
            cfg_sync = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 399) == 0) pll_lock = 1'b0;
            else if (!pll_lock && $urandom_range(0, 2) == 0) pll_lock = 1'b1;
            @(negedge clk_96M);
        end
        cfg_we   = 1'b0;
        cfg_sync = 1'b0;
        pll_lock = 1'b1;
        repeat (30) @(negedge clk_96M);

        // Reset in RUN with a changed divisor.
        wr_div(0, 7);
        repeat (20) @(negedge clk_96M);
        n_reset = 1'b0;
        @(negedge clk_96M);
        check_eq("mreset_rst_out_n", 32'(rst_out_n), 32'd0);
        check_eq("mreset_ce", 32'(ce), 32'd0);
        check_eq("mreset_sq", 32'(sq), 32'd0);
        check_eq("mreset_lock_lost", 32'(lock_lost), 32'd0);
        n_reset = 1'b1;
        edge_gap(1'b0, 0, 400, gap);
        check_eq("mreset_def_div", gap, 32'd96);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
